uart_brg_os: RTL and testbench
==============================

// Module: uart_brg_os
// PURPOSE
//  Fractional baud-rate generator for the UART. Emits an oversampling tick, a
//  bit tick every OS_RATE oversampling ticks, and a mid-bit sampling strobe.
//  A Sync input re-phases the generator to an RX start-bit edge. Prescale
//  updates are shadowed, so a bit period already in progress is never
//  corrupted. Feeds both uart_tx (baud_tick) and uart_rx (os_tick/mid_tick).
// PARAMETERS
//  PRE_W    16  prescale width, unsigned fixed-point Q(PRE_W-FRAC_W).FRAC_W
//  FRAC_W   4   fractional bits of Prescale, 1..PRE_W-2
//  OS_RATE  16  os_ticks per bit, 2..256 (power of two not required)
//  OS_W     $clog2(OS_RATE)  width of os_phase (derived, do not override)
// PORTS
//  Clk       in   1      clock
//  Rst_n     in   1      synchronous reset, active low
//  En        in   1      run enable; 0 holds block idle
//  Sync      in   1      restart bit phase (RX start-bit detect), 1-cycle pulse
//  Prescale  in   PRE_W  Clk cycles per os_tick, fixed point
//  os_tick   out  1      oversampling pulse, 1 cycle wide
//  baud_tick out  1      bit-boundary pulse, coincident with an os_tick
//  mid_tick  out  1      mid-bit pulse (UART_BRG_MIDBIT_EN only, else 0)
//  os_phase  out  OS_W   os_tick index within current bit, 0..OS_RATE-1
// BEHAVIOUR
//  - Reset (Rst_n=0 at posedge) or En=0: all counters, frac accumulator, ovf
//    flag and os_phase cleared; all tick outputs 0 next cycle. Reset wins.
//  - States: IDLE (En=0) -> LOAD (first cycle with En=1: Prescale latched
//    into active reg, int counter = INT-1, no tick) -> RUN.
//  - Int part INT = Prescale[PRE_W-1:FRAC_W]; INT=0 is treated as 1.
//  - RUN: int counter decrements each cycle; at 0 it asserts os_tick, reloads
//    INT-1, and adds FRAC to the FRAC_W-bit accumulator (wraps mod 2^FRAC_W).
//    A carry out inserts exactly one stall cycle before the count resumes.
//    Period = INT cycles, +1 on carry; average = Prescale/2^FRAC_W cycles.
//  - os_phase increments on each os_tick and wraps OS_RATE-1 -> 0. The os_tick
//    that wraps it also asserts baud_tick.
//  - Shadowing: the active prescale reg reloads from Prescale only in LOAD, on
//    the baud_tick cycle, and on Sync. Changes elsewhere take effect next bit.
//  - Sync (En=1): next cycle behaves as LOAD. os_phase=0, accumulator=0, ovf
//    cleared, no tick that cycle; first os_tick INT cycles later. A Sync in
//    the same cycle as a pending tick suppresses that tick. Sync with En=0
//    is ignored.
//  - First baud_tick after LOAD/Sync comes OS_RATE os_ticks later (one full
//    bit); first mid_tick comes after floor(OS_RATE/2) os_ticks.
//  - Outputs are registered, 1-cycle pulses; never asserted in IDLE.
//  - En falling mid-bit: immediate return to IDLE, no residual tick.
// CONFIGURATION
//  UART_BRG_MIDBIT_EN defined: mid_tick asserts on the os_tick at which
//   os_phase becomes floor(OS_RATE/2) (RX sample point).
//  Not defined: mid_tick is tied to 0; no compare logic is synthesised.
// TESTING
//  1 Prescale=16'h0034, OS_RATE=16, En=1 -> os_tick periods 3,3,3,4
//    repeating; baud_tick exactly every 52 Clk cycles.
//  2 Prescale=16'h0010 (INT=1, FRAC=0) -> os_tick every cycle; baud_tick
//    every 16 cycles; Prescale=16'h0008 (INT=0) behaves as INT=1 plus frac.
//  3 Change Prescale 0x0034->0x0060 at os_phase=5 -> rest of bit stays
//    3.25-cycle spacing; after next baud_tick spacing is 6 cycles.
//  4 Sync at os_phase=9 -> os_phase=0, next os_tick INT cycles later,
//    mid_tick after 8 os_ticks, baud_tick after 16 os_ticks.
//  5 Rst_n=0 or En=0 mid-bit, with a tick due that cycle -> no tick emitted;
//    os_phase=0; restart matches scenario 1 from LOAD.
//  6 MIDBIT_EN on/off with OS_RATE=7 -> mid_tick at os_phase=3 / stuck at 0.

Source files
------------

// File: rtl/uart_brg_os.sv
// uart_brg_os: fractional baud-rate generator producing os_tick, baud_tick and mid-bit strobe.
// Define UART_BRG_MIDBIT_EN to enable the mid_tick strobe; otherwise mid_tick is tied low.
module uart_brg_os #(
    parameter  int PRE_W   = 16,
    parameter  int FRAC_W  = 4,
    parameter  int OS_RATE = 16,
    localparam int OS_W    = $clog2(OS_RATE)
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             En,
    input  logic             Sync,
    input  logic [PRE_W-1:0] Prescale,
    output logic             os_tick,
    output logic             baud_tick,
    output logic             mid_tick,
    output logic [OS_W-1:0]  os_phase
);

    localparam int INT_W = PRE_W - FRAC_W;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [OS_W-1:0] PH_LAST = OS_W'(OS_RATE - 1);

    logic [0:0]        r_state;
    logic [PRE_W-1:0]  r_pre;
    logic [INT_W-1:0]  r_cnt;
    logic [FRAC_W-1:0] r_acc;
    logic              r_ovf;
    logic [OS_W-1:0]   r_phase;
    logic              r_os;
    logic              r_baud;

    logic [INT_W-1:0]  w_in_int;
    logic [INT_W-1:0]  w_act_int;
    logic [INT_W-1:0]  w_next_int;
    logic [PRE_W-1:0]  w_next_pre;
    logic [FRAC_W:0]   w_sum;
    logic              w_load;
    logic              w_tick;
    logic              w_wrap;
    logic [OS_W-1:0]   w_phase_nxt;

    // The bit-boundary tick switches to the freshly shadowed prescale, so the
    // period following baud_tick already uses the new integer and fraction.
    always_comb begin
        w_in_int = Prescale[PRE_W-1:FRAC_W];
        if (w_in_int == '0) w_in_int = INT_W'(1);
        w_act_int = r_pre[PRE_W-1:FRAC_W];
        if (w_act_int == '0) w_act_int = INT_W'(1);
        w_load      = (r_state == S_IDLE) || Sync;
        w_tick      = (r_state == S_RUN) && !r_ovf && (r_cnt == '0);
        w_wrap      = w_tick && (r_phase == PH_LAST);
        w_next_pre  = w_wrap ? Prescale : r_pre;
        w_next_int  = w_wrap ? w_in_int : w_act_int;
        w_sum       = {1'b0, r_acc} + {1'b0, w_next_pre[FRAC_W-1:0]};
        w_phase_nxt = w_wrap ? '0 : r_phase + 1'b1;
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n || !En) begin
            r_state <= S_IDLE;
            r_pre   <= '0;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_phase <= '0;
            r_os    <= 1'b0;
            r_baud  <= 1'b0;
        end else if (w_load) begin
            r_state <= S_RUN;
            r_pre   <= Prescale;
            r_cnt   <= w_in_int - 1'b1;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_phase <= '0;
            r_os    <= 1'b0;
            r_baud  <= 1'b0;
        end else begin
            r_os   <= w_tick;
            r_baud <= w_wrap;
            // A fraction carry costs one stall cycle before counting resumes.
            if (r_ovf) begin
                r_ovf <= 1'b0;
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end else begin
                r_pre   <= w_next_pre;
                r_cnt   <= w_next_int - 1'b1;
                r_acc   <= w_sum[FRAC_W-1:0];
                r_ovf   <= w_sum[FRAC_W];
                r_phase <= w_phase_nxt;
            end
        end
    end

`ifdef UART_BRG_MIDBIT_EN
    localparam logic [OS_W-1:0] PH_MID = OS_W'(OS_RATE / 2);

    logic r_mid;

    always_ff @(posedge Clk) begin
        if (!Rst_n || !En || w_load) begin
            r_mid <= 1'b0;
        end else begin
            r_mid <= w_tick && (w_phase_nxt == PH_MID);
        end
    end

    assign mid_tick = r_mid;
`else
    assign mid_tick = 1'b0;
`endif

    assign os_tick   = r_os;
    assign baud_tick = r_baud;
    assign os_phase  = r_phase;

endmodule

// File: tb/tb_uart_brg_os.sv
// tb_uart_brg_os: event-scheduled reference model for two generator instances
// (OS_RATE 16 and 7), directed scenarios with literal timings, then random stimulus.
`timescale 1ns/1ps
module tb_uart_brg_os;

    localparam int FRAC_W = 4;
    localparam int NI     = 2;
`ifdef UART_BRG_MIDBIT_EN
    localparam bit MID_EN = 1'b1;
`else
    localparam bit MID_EN = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        En;
    logic        Sync;
    logic [15:0] Prescale;

    logic        os0, baud0, mid0;
    logic [3:0]  ph0;
    logic        os1, baud1, mid1;
    logic [2:0]  ph1;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    int osr[NI] = '{16, 7};
    bit m_run[NI];
    int m_pre[NI];
    int m_due[NI];
    int m_acc[NI];
    int m_ph[NI];
    bit e_os[NI];
    bit e_baud[NI];
    bit e_mid[NI];

    always #5 Clk = ~Clk;

    uart_brg_os #(.PRE_W(16), .FRAC_W(4), .OS_RATE(16)) u_dut0 (
        .Clk(Clk), .Rst_n(Rst_n), .En(En), .Sync(Sync), .Prescale(Prescale),
        .os_tick(os0), .baud_tick(baud0), .mid_tick(mid0), .os_phase(ph0)
    );

    uart_brg_os #(.PRE_W(16), .FRAC_W(4), .OS_RATE(7)) u_dut1 (
        .Clk(Clk), .Rst_n(Rst_n), .En(En), .Sync(Sync), .Prescale(Prescale),
        .os_tick(os1), .baud_tick(baud1), .mid_tick(mid1), .os_phase(ph1)
    );

    function automatic int pint(input int p);
        int v;
        v = p >> FRAC_W;
        return (v == 0) ? 1 : v;
    endfunction

    function automatic int pfrac(input int p);
        return p & ((1 << FRAC_W) - 1);
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Model: each instance keeps the absolute cycle of its next os_tick.
    always @(posedge Clk) begin
        logic [7:0] act;
        logic [7:0] exp;
        int         carry;
        cyc = cyc + 1;
        for (int k = 0; k < NI; k++) begin
            e_os[k]   = 1'b0;
            e_baud[k] = 1'b0;
            e_mid[k]  = 1'b0;
            if (!Rst_n || !En) begin
                m_run[k] = 1'b0;
                m_ph[k]  = 0;
            end else if (!m_run[k] || Sync) begin
                m_run[k] = 1'b1;
                m_pre[k] = int'(Prescale);
                m_due[k] = cyc + pint(m_pre[k]);
                m_acc[k] = 0;
                m_ph[k]  = 0;
            end else if (cyc == m_due[k]) begin
                e_os[k] = 1'b1;
                if (m_ph[k] == osr[k] - 1) begin
                    e_baud[k] = 1'b1;
                    m_ph[k]   = 0;
                    m_pre[k]  = int'(Prescale);
                end else begin
                    m_ph[k] = m_ph[k] + 1;
                end
                e_mid[k] = MID_EN && (m_ph[k] == osr[k] / 2);
                m_acc[k] = m_acc[k] + pfrac(m_pre[k]);
                carry    = (m_acc[k] >= (1 << FRAC_W)) ? 1 : 0;
                m_acc[k] = m_acc[k] % (1 << FRAC_W);
                m_due[k] = cyc + pint(m_pre[k]) + carry;
            end
        end
        #1;
        for (int k = 0; k < NI; k++) begin
            if (k == 0) begin
                act = {1'b0, os0, baud0, mid0, ph0};
                exp = {1'b0, e_os[0], e_baud[0], e_mid[0], 4'(m_ph[0])};
            end else begin
                act = {2'b0, os1, baud1, mid1, ph1};
                exp = {2'b0, e_os[1], e_baud[1], e_mid[1], 3'(m_ph[1])};
            end
            n_chk++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL model_dut%0d: got {os,baud,mid,phase}=%h, required %h (cycle %0d)",
                         k, act, exp, cyc);
            end
        end
    end

    task automatic nstep();
        @(negedge Clk);
        Sync = 1'b0;
    endtask

    // sel: 0 = os_tick of dut0, 1 = baud_tick of dut0, 2 = os_tick of dut1
    task automatic wait_sig(input int sel, output int t);
        t = -1;
        for (int i = 0; i < 300; i++) begin
            nstep();
            if ((sel == 0 && os0 === 1'b1) || (sel == 1 && baud0 === 1'b1) ||
                (sel == 2 && os1 === 1'b1)) begin
                t = cyc;
                return;
            end
        end
        n_chk++;
        n_fail++;
        $display("FAIL wait_sig%0d: got no pulse, required one within 300 cycles", sel);
    endtask

    task automatic resync(input logic [15:0] p, output int l);
        Prescale = p;
        Sync     = 1'b1;
        l        = cyc + 1;
    endtask

    task automatic wait_due();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (m_run[0] && m_due[0] == cyc + 1) begin
                found = 1'b1;
                break;
            end
            nstep();
        end
        check("due_found", int'(found), 1);
    endtask

    initial begin : stim
        int l, s, t, b1, b2, cnt, midat, phat, midcnt, r;
        int tt[9];
        int p1[8] = '{3, 3, 3, 4, 3, 3, 3, 4};
        int p2[4] = '{1, 2, 1, 2};

        Rst_n = 1'b0; En = 1'b0; Sync = 1'b0; Prescale = '0;
        repeat (3) nstep();
        check("rst_os", int'(os0), 0);
        check("rst_baud", int'(baud0), 0);
        check("rst_phase", int'(ph0), 0);
        Rst_n = 1'b1;
        nstep();
        check("idle_os", int'(os0), 0);

        // Scenario 1: 0x0034 -> periods 3,3,3,4; baud every 52
        Prescale = 16'h0034; En = 1'b1; l = cyc + 1;
        for (int i = 0; i < 9; i++) wait_sig(0, tt[i]);
        check("s1_first_os", tt[0] - l, 3);
        for (int i = 0; i < 8; i++) check("s1_os_period", tt[i+1] - tt[i], p1[i]);
        wait_sig(1, b1);
        wait_sig(1, b2);
        check("s1_first_baud", b1 - l, 51);
        check("s1_baud_period", b2 - b1, 52);

        // Scenario 2: INT=1 and INT=0 with fraction
        resync(16'h0010, l);
        wait_sig(0, tt[0]);
        wait_sig(0, tt[1]);
        check("s2_first_os", tt[0] - l, 1);
        check("s2_os_period", tt[1] - tt[0], 1);
        wait_sig(1, b1);
        wait_sig(1, b2);
        check("s2_baud_period", b2 - b1, 16);
        resync(16'h0008, l);
        for (int i = 0; i < 5; i++) wait_sig(0, tt[i]);
        check("s2b_first_os", tt[0] - l, 1);
        for (int i = 0; i < 4; i++) check("s2b_os_period", tt[i+1] - tt[i], p2[i]);

        // Scenario 3: prescale change mid-bit takes effect after baud_tick
        resync(16'h0034, l);
        for (int i = 0; i < 40; i++) begin
            wait_sig(0, t);
            if (ph0 == 4'd5) break;
        end
        check("s3_phase5_time", t - l, 16);
        Prescale = 16'h0060;
        wait_sig(1, b1);
        check("s3_baud_time", b1 - l, 51);
        wait_sig(0, tt[0]);
        wait_sig(0, tt[1]);
        check("s3_new_period0", tt[0] - b1, 6);
        check("s3_new_period1", tt[1] - tt[0], 6);
        wait_sig(1, b2);
        check("s3_new_baud", b2 - b1, 96);

        // Scenario 4: Sync at os_phase 9
        resync(16'h0034, l);
        for (int i = 0; i < 40; i++) begin
            wait_sig(0, t);
            if (ph0 == 4'd9) break;
        end
        check("s4_phase_before", int'(ph0), 9);
        Sync = 1'b1; s = cyc + 1;
        nstep();
        check("s4_phase_after", int'(ph0), 0);
        check("s4_no_tick", int'(os0), 0);
        wait_sig(0, t);
        check("s4_first_os", t - s, 3);
        cnt = 1; midat = -1;
        for (int i = 0; i < 40 && baud0 !== 1'b1; i++) begin
            wait_sig(0, t);
            cnt++;
            if (mid0 === 1'b1 && midat < 0) midat = cnt;
        end
        check("s4_ticks_to_baud", cnt, 16);
        check("s4_mid_at", midat, MID_EN ? 8 : -1);

        // Scenario 5: En drop and reset with a tick due
        for (int i = 0; i < 3; i++) wait_sig(0, t);
        wait_due();
        En = 1'b0;
        nstep();
        check("s5_en_tick", int'(os0), 0);
        check("s5_en_phase", int'(ph0), 0);
        En = 1'b1; l = cyc + 1;
        wait_sig(0, t);
        check("s5_en_first_os", t - l, 3);
        wait_sig(1, b1);
        check("s5_en_first_baud", b1 - l, 51);
        for (int i = 0; i < 2; i++) wait_sig(0, t);
        wait_due();
        Rst_n = 1'b0;
        nstep();
        check("s5_rst_tick", int'(os0), 0);
        check("s5_rst_phase", int'(ph0), 0);
        Rst_n = 1'b1; l = cyc + 1;
        wait_sig(0, t);
        check("s5_rst_first_os", t - l, 3);
        wait_sig(1, b1);
        check("s5_rst_first_baud", b1 - l, 51);

        // Scenario 6: OS_RATE=7 mid-bit strobe
        resync(16'h0034, l);
        cnt = 0; midat = -1; phat = -1; midcnt = 0;
        for (int i = 0; i < 7; i++) begin
            wait_sig(2, t);
            cnt++;
            if (mid1 === 1'b1) begin
                midcnt++;
                if (midat < 0) begin
                    midat = cnt;
                    phat  = int'(ph1);
                end
            end
        end
        check("s6_baud_at_7", int'(baud1), 1);
        check("s6_mid_at", midat, MID_EN ? 3 : -1);
        check("s6_mid_phase", phat, MID_EN ? 3 : -1);
        check("s6_mid_count", midcnt, MID_EN ? 1 : 0);

        // Random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            nstep();
            r = int'($urandom_range(0, 999));
            if (r < 30) Prescale = 16'($urandom_range(0, 127));
            else if (r < 50) Sync = 1'b1;
            else if (r < 55) En = ~En;
            else if (r < 57) Rst_n = 1'b0;
            else begin
                Rst_n = 1'b1;
                if (!En && r >= 900) En = 1'b1;
            end
        end
        nstep();
        nstep();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
